// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath/memory side (slave).
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [6:0]       Opcode;
  logic             mem_ready;
  logic             InstrRead;
  logic             IRWrite;
  logic             PCWrite;
  logic             Branch;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             ALUSrc;
  logic             RegWrite;
  logic [1:0]       ALUOp;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, Opcode, mem_ready,
    output InstrRead, IRWrite, PCWrite, Branch, MemRead, MemWrite, MemtoReg,
           ALUSrc, RegWrite, ALUOp, state, illegal, retired
  );

  modport slave (
    output run, Opcode, mem_ready,
    input  InstrRead, IRWrite, PCWrite, Branch, MemRead, MemWrite, MemtoReg,
           ALUSrc, RegWrite, ALUOp, state, illegal, retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for a single-memory-port RISC-V datapath.
// Enables are a decode of the state and the opcode latched in DECODE; retired counts completed instructions.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.master bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t           state_reg;
  logic [6:0]       opcode_q;
  logic             illegal_reg;
  logic [CNT_W-1:0] retired_reg;

  function automatic logic supported(input logic [6:0] op);
    return op inside {OP_R, OP_LD, OP_ADDI, OP_SD, OP_BEQ};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= FETCH;
      opcode_q    <= '0;
      illegal_reg <= 1'b0;
      retired_reg <= '0;
    end else begin
      illegal_reg <= 1'b0;
      case (state_reg)
        FETCH: if (bus.run && bus.mem_ready) state_reg <= DECODE;
        DECODE: begin
          opcode_q <= bus.Opcode;
          if (supported(bus.Opcode)) begin
            state_reg <= EXEC;
          end else begin
            state_reg   <= FETCH;
            illegal_reg <= 1'b1;
          end
        end
        EXEC: begin
          case (opcode_q)
            OP_R, OP_ADDI: state_reg <= WB;
            OP_LD, OP_SD:  state_reg <= MEM;
            OP_BEQ: begin
              state_reg   <= FETCH;
              retired_reg <= retired_reg + CNT_W'(1);
            end
            default: state_reg <= FETCH;
          endcase
        end
        MEM: begin
          if (bus.mem_ready) begin
            if (opcode_q == OP_LD) begin
              state_reg <= WB;
            end else begin
              state_reg   <= FETCH;
              retired_reg <= retired_reg + CNT_W'(1);
            end
          end
        end
        WB: begin
          state_reg   <= FETCH;
          retired_reg <= retired_reg + CNT_W'(1);
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  logic       instr_read, ir_write, pc_write, branch, mem_read, mem_write;
  logic       mem_to_reg, alu_src, reg_write;
  logic [1:0] alu_op;

  always_comb begin
    instr_read = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    case (state_reg)
      FETCH: begin
        instr_read = bus.run;
        ir_write   = bus.run & bus.mem_ready;
        pc_write   = bus.run & bus.mem_ready;
      end
      EXEC: begin
        case (opcode_q)
          OP_R:                 alu_op  = 2'b10;
          OP_LD, OP_ADDI, OP_SD: alu_src = 1'b1;
          OP_BEQ: begin
            alu_op = 2'b01;
            branch = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        // ALU operand select stays at its EXEC value so the address holds through a stall
        alu_src   = (opcode_q == OP_LD) || (opcode_q == OP_SD);
        mem_read  = (opcode_q == OP_LD);
        mem_write = (opcode_q == OP_SD);
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode_q == OP_LD);
      end
      default: ;
    endcase
  end

  // Every output is forced low while reset is held, including the run-driven fetch request
  assign bus.InstrRead = reset & instr_read;
  assign bus.IRWrite   = reset & ir_write;
  assign bus.PCWrite   = reset & pc_write;
  assign bus.Branch    = reset & branch;
  assign bus.MemRead   = reset & mem_read;
  assign bus.MemWrite  = reset & mem_write;
  assign bus.MemtoReg  = reset & mem_to_reg;
  assign bus.ALUSrc    = reset & alu_src;
  assign bus.RegWrite  = reset & reg_write;
  assign bus.ALUOp     = reset ? alu_op : 2'b00;
  assign bus.state     = reset ? state_reg : 3'd0;
  assign bus.illegal   = illegal_reg;
  assign bus.retired   = retired_reg;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: builds expected per-cycle traces from the instruction rules and compares every cycle.
module tb_multicycle_control_fsm;
  localparam int CNT_W = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  // Control word bits: InstrRead IRWrite PCWrite Branch MemRead MemWrite MemtoReg ALUSrc RegWrite ALUOp[1:0]
  localparam logic [10:0] IR   = 11'b100_0000_0000;
  localparam logic [10:0] IRW  = 11'b010_0000_0000;
  localparam logic [10:0] PCW  = 11'b001_0000_0000;
  localparam logic [10:0] BR   = 11'b000_1000_0000;
  localparam logic [10:0] MR   = 11'b000_0100_0000;
  localparam logic [10:0] MW   = 11'b000_0010_0000;
  localparam logic [10:0] M2R  = 11'b000_0001_0000;
  localparam logic [10:0] ASRC = 11'b000_0000_1000;
  localparam logic [10:0] RW   = 11'b000_0000_0100;
  localparam logic [10:0] ASUB = 11'b000_0000_0001;
  localparam logic [10:0] AFN  = 11'b000_0000_0010;

  localparam int EXP_W = 3 + 11 + 1 + CNT_W;

  typedef struct {
    logic [EXP_W-1:0] exp;
    logic             run;
    logic [6:0]       op;
    logic             rdy;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();
  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ret = 0;
  bit pend_ill = 1'b0;
  ent_t tr[$];
  logic [EXP_W-1:0] obs;

  function automatic logic [6:0] r7();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic logic r1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic [2:0] st, input logic [10:0] c,
                               input logic run, input logic [6:0] op, input logic rdy);
    ent_t e;
    e.exp = {st, c, pend_ill, CNT_W'(exp_ret)};
    e.run = run;
    e.op  = op;
    e.rdy = rdy;
    tr.push_back(e);
    pend_ill = 1'b0;
  endfunction

  function automatic void build_idle(input int n);
    for (int i = 0; i < n; i++) push(3'd0, 11'd0, 1'b0, r7(), r1());
  endfunction

  // One instruction: fetch stalls, fetch, decode, then the opcode's phases; mst = MEM stall cycles
  function automatic void build_instr(input logic [6:0] op, input int fst, input int mst);
    bit legal = 1'b1;
    for (int i = 0; i < fst; i++) push(3'd0, IR, 1'b1, r7(), 1'b0);
    push(3'd0, IR | IRW | PCW, 1'b1, r7(), 1'b1);
    push(3'd1, 11'd0, r1(), op, r1());
    case (op)
      OP_R: begin
        push(3'd2, AFN, r1(), r7(), r1());
        push(3'd4, RW, r1(), r7(), r1());
      end
      OP_ADDI: begin
        push(3'd2, ASRC, r1(), r7(), r1());
        push(3'd4, RW, r1(), r7(), r1());
      end
      OP_LD: begin
        push(3'd2, ASRC, r1(), r7(), r1());
        for (int m = 0; m <= mst; m++) push(3'd3, MR | ASRC, r1(), r7(), m == mst);
        push(3'd4, RW | M2R, r1(), r7(), r1());
      end
      OP_SD: begin
        push(3'd2, ASRC, r1(), r7(), r1());
        for (int m = 0; m <= mst; m++) push(3'd3, MW | ASRC, r1(), r7(), m == mst);
      end
      OP_BEQ: push(3'd2, BR | ASUB, r1(), r7(), r1());
      default: legal = 1'b0;
    endcase
    if (legal) exp_ret = (exp_ret + 1) % (1 << CNT_W);
    else pend_ill = 1'b1;
  endfunction

  task automatic sample();
    obs = {bus.state, bus.InstrRead, bus.IRWrite, bus.PCWrite, bus.Branch, bus.MemRead,
           bus.MemWrite, bus.MemtoReg, bus.ALUSrc, bus.RegWrite, bus.ALUOp, bus.illegal, bus.retired};
  endtask

  task automatic drive(input ent_t e);
    @(negedge clk);
    bus.run       = e.run;
    bus.Opcode    = e.op;
    bus.mem_ready = e.rdy;
    #1;
    sample();
  endtask

  task automatic test_reset();
    bus.run = 1'b0; bus.Opcode = '0; bus.mem_ready = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.run = 1'b1; bus.Opcode = r7(); bus.mem_ready = r1();
      #1;
      sample();
      n_tests++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, obs, {EXP_W{1'b0}});
      end
    end
    bus.run = 1'b0;
    reset = 1'b1;
    exp_ret = 0;
    pend_ill = 1'b0;
  endtask

  task automatic test_r_type();
    build_instr(OP_R, 0, 0);
    build_idle(1);
    foreach (tr[i]) begin
      drive(tr[i]);
      n_tests++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL r_type cyc%0d got=%h exp=%h", i, obs, tr[i].exp);
      end
    end
    tr.delete();
  endtask

  task automatic test_ld_stall();
    build_instr(OP_LD, 0, 2);
    build_idle(1);
    foreach (tr[i]) begin
      drive(tr[i]);
      n_tests++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL ld_stall cyc%0d got=%h exp=%h", i, obs, tr[i].exp);
      end
    end
    tr.delete();
  endtask

  task automatic test_sd_beq();
    build_instr(OP_SD, 1, 1);
    build_instr(OP_BEQ, 0, 0);
    build_idle(1);
    foreach (tr[i]) begin
      drive(tr[i]);
      n_tests++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL sd_beq cyc%0d got=%h exp=%h", i, obs, tr[i].exp);
      end
    end
    tr.delete();
  endtask

  task automatic test_illegal();
    build_instr(7'b1111111, 0, 0);
    build_idle(2);
    build_instr(7'b0000000, 1, 0);
    build_instr(OP_ADDI, 0, 0);
    foreach (tr[i]) begin
      drive(tr[i]);
      n_tests++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL illegal cyc%0d got=%h exp=%h", i, obs, tr[i].exp);
      end
    end
    tr.delete();
  endtask

  task automatic test_run_low();
    build_idle(5);
    build_instr(OP_ADDI, 0, 0);
    build_idle(1);
    foreach (tr[i]) begin
      drive(tr[i]);
      n_tests++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL run_low cyc%0d got=%h exp=%h", i, obs, tr[i].exp);
      end
    end
    tr.delete();
  endtask

  task automatic test_reset_mid();
    build_instr(OP_LD, 0, 5);
    for (int i = 0; i < 5; i++) begin
      drive(tr[i]);
      n_tests++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL reset_mid cyc%0d got=%h exp=%h", i, obs, tr[i].exp);
      end
    end
    tr.delete();
    // Assert reset between clock edges while MEM is stalled
    #2;
    bus.run = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      sample();
      n_tests++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_hold cyc%0d got=%h exp=%h", i, obs, {EXP_W{1'b0}});
      end
      @(negedge clk);
    end
    bus.run = 1'b0;
    reset = 1'b1;
    exp_ret = 0;
    pend_ill = 1'b0;
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 16; k++) build_instr(OP_ADDI, 0, 0);
    build_idle(1);
    foreach (tr[i]) begin
      drive(tr[i]);
      n_tests++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL wrap cyc%0d got=%h exp=%h", i, obs, tr[i].exp);
      end
    end
    tr.delete();
    n_tests++;
    if (bus.retired !== CNT_W'(0)) begin
      n_fail++;
      $display("FAIL wrap_final got=%0d exp=0", bus.retired);
    end
  endtask

  task automatic test_random();
    logic [6:0] op;
    for (int k = 0; k < 40; k++) begin
      build_idle($urandom_range(0, 2));
      case ($urandom_range(0, 5))
        0: op = OP_R;
        1: op = OP_LD;
        2: op = OP_ADDI;
        3: op = OP_SD;
        4: op = OP_BEQ;
        default: op = r7();
      endcase
      build_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    build_idle(1);
    foreach (tr[i]) begin
      drive(tr[i]);
      n_tests++;
      if (obs !== tr[i].exp) begin
        n_fail++;
        $display("FAIL random cyc%0d got=%h exp=%h", i, obs, tr[i].exp);
      end
    end
    tr.delete();
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_ld_stall();
    test_sd_beq();
    test_illegal();
    test_run_low();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
